// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared encodings and defaults for the LIFO controller
package stack_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 6;
  localparam int AW_DEF    = 3;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  // A rejected command produces an error response and leaves stack and memory untouched.
  function automatic logic cmd_rejected(input op_e op, input logic full, input logic empty);
    return ((op == OP_PUSH) && full) ||
           (((op == OP_POP) || (op == OP_PEEK)) && empty);
  endfunction

endpackage

// File: rtl/stack_mem_if.sv
// rtl/stack_mem_if.sv - falling-edge launch registers for the register-file memory pins
module stack_mem_if
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             access_en,
  input  logic             access_wr,
  input  logic [AW-1:0]    access_adr,
  input  logic [WIDTH-1:0] access_di,
  output logic [AW-1:0]    adr,
  output logic             en,
  output logic             wr,
  output logic [WIDTH-1:0] di
);

  // The memory gates CLK with EN, so pins must settle before the high phase begins.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      adr <= '0;
      en  <= 1'b0;
      wr  <= 1'b0;
      di  <= '0;
    end else begin
      en <= access_en;
      wr <= access_en && access_wr;
      if (access_en) begin
        adr <= access_adr;
      end
      if (access_en && access_wr) begin
        di <= access_di;
      end
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - LIFO command controller in front of a small register-file memory
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR,
  output logic             FULL,
  output logic             EMPTY,
  output logic [AW-1:0]    COUNT,
  output logic [AW-1:0]    MEM_ADR,
  output logic             MEM_EN,
  output logic             MEM_WR,
  output logic [WIDTH-1:0] MEM_DI,
  input  logic [WIDTH-1:0] MEM_DO
);

  localparam logic [AW-1:0] CNT_FULL = AW'(DEPTH);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  state_e           state;
  op_e              held_op;
  logic [WIDTH-1:0] held_data;
  logic [AW-1:0]    count;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] rsp_data;

  logic             access_en;
  logic             access_wr;
  logic [AW-1:0]    access_adr;
  op_e              cmd_op;

  assign cmd_op    = op_e'(CMD_OP);
  assign FULL      = (count == CNT_FULL);
  assign EMPTY     = (count == '0);
  assign COUNT     = count;
  assign CMD_READY = RST_N && (state == S_IDLE);
  assign RSP_VALID = rsp_valid;
  assign RSP_DATA  = rsp_data;
  assign RSP_ERR   = rsp_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      held_op   <= OP_PUSH;
      held_data <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            held_op   <= cmd_op;
            held_data <= CMD_DATA;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            if (cmd_rejected(cmd_op, FULL, EMPTY)) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              case (cmd_op)
                OP_PUSH: state <= S_WRITE;
                OP_POP,
                OP_PEEK: state <= S_READ;
                default: begin
                  count     <= '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
                end
              endcase
            end
          end
        end
        S_WRITE: begin
          count     <= count + CNT_ONE;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_READ: begin
          rsp_data <= MEM_DO;
          if (held_op == OP_POP) begin
            count <= count - CNT_ONE;
          end
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        default: begin
          if (RSP_READY) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Access request seen by the falling-edge launch registers; the top of stack sits at count-1.
  always_comb begin
    access_en  = 1'b0;
    access_wr  = 1'b0;
    access_adr = count;
    case (state)
      S_WRITE: begin
        access_en = 1'b1;
        access_wr = 1'b1;
      end
      S_READ: begin
        access_en  = 1'b1;
        access_adr = count - CNT_ONE;
      end
      default: begin
        access_en = 1'b0;
      end
    endcase
  end

  stack_mem_if #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_mem_if (
    .clk       (CLK),
    .rst_n     (RST_N),
    .access_en (access_en),
    .access_wr (access_wr),
    .access_adr(access_adr),
    .access_di (held_data),
    .adr       (MEM_ADR),
    .en        (MEM_EN),
    .wr        (MEM_WR),
    .di        (MEM_DI)
  );

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- LIFO controller that sits directly upstream of the 6-word x 4-bit register-file memory.
- Accepts push/pop/peek/clear commands over a valid/ready handshake.
- Drives the memory's address, enable, write and data-in pins, and samples its data-out.
- Returns one response per command: data and error flag, with valid/ready.

Parameters:
- WIDTH, 4, data word width; must match the memory data width.
- DEPTH, 6, number of usable memory words; must be less than or equal to 2**AW.
- AW, 3, address width; must match the memory address width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  controller can accept a command.
- CMD_OP  in  2  command: 00 push, 01 pop, 10 peek, 11 clear.
- CMD_DATA  in  WIDTH  push data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  WIDTH  popped or peeked word; 0 for push and clear.
- RSP_ERR  out  1  overflow or underflow; command had no effect.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  AW  current number of stored words (the stack pointer).
- MEM_ADR  out  AW  to memory ADR2..ADR0.
- MEM_EN  out  1  to memory EN.
- MEM_WR  out  1  to memory WR.
- MEM_DI  out  WIDTH  to memory DI3..DI0.
- MEM_DO  in  WIDTH  from memory DO3..DO0.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-low (RST_N).
- Edge usage: the FSM, COUNT and response registers update on the rising edge. MEM_ADR, MEM_EN, MEM_WR and MEM_DI are registered on the falling edge of CLK. This keeps them stable across the whole CLK-high phase, because the memory gates CLK with EN and writes on the gated rising edge.
- Reset values:
  - COUNT=0, state IDLE, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0.
  - MEM_EN=0, MEM_WR=0, MEM_ADR=0, MEM_DI=0; these memory-side registers clear at any falling edge sampled with RST_N low.
  - CMD_READY=0 while RST_N is low.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - CMD_READY=1.
  - Command accepted at a rising edge with CMD_VALID=1; op and data are latched.
  - Push with FULL, or pop/peek with EMPTY -> RESP with ERR=1; no memory access and COUNT unchanged.
  - Clear -> COUNT=0, RESP with ERR=0, no memory access.
  - Push -> WRITE.
  - Pop/peek -> READ.
- WRITE (exactly 1 cycle):
  - Following falling edge drives MEM_ADR=COUNT, MEM_DI=data, MEM_EN=1, MEM_WR=1.
  - The memory writes at the next rising edge.
  - At that same rising edge: COUNT+1, -> RESP.
- READ (exactly 1 cycle):
  - Following falling edge drives MEM_ADR=COUNT-1, MEM_EN=1, MEM_WR=0.
  - At the next rising edge, MEM_DO is captured into RSP_DATA.
  - Pop: COUNT-1. Peek: COUNT unchanged. Then -> RESP.
- Memory-side outputs in IDLE and RESP: MEM_EN=0 and MEM_WR=0 at the following falling edge. MEM_ADR and MEM_DI hold their last values.
- RESP:
  - RSP_VALID=1; RSP_DATA and RSP_ERR held stable.
  - Rising edge with RSP_READY=1 -> IDLE, RSP_VALID=0.
  - No new command is accepted until the cycle after the response handshake; one command is outstanding at most.
- Latency: command accept to RSP_VALID is 2 rising edges for push/pop/peek and 1 for error/clear.
- COUNT never exceeds DEPTH and never wraps. Memory addresses DEPTH..2**AW-1 are never driven.
- FULL and EMPTY are combinational from COUNT.
- Reset mid-operation:
  - A write strobe already launched may still complete at the next rising edge.
  - COUNT returns to 0 regardless, so memory contents are don't-care.
  - No response is produced for the interrupted command.

Decomposition:
- Shared package:
  - op encodings: OP_PUSH, OP_POP, OP_PEEK, OP_CLR;
  - state encoding;
  - WIDTH/AW/DEPTH defaults.
- Sub-module: stack_mem_if, which holds the falling-edge registers for MEM_ADR/MEM_EN/MEM_WR/MEM_DI, driven by a next-access request from the FSM.
- FSM, counter and response logic stay in stack_ctrl.

Test Plan:
- Reset, then push 0x3 with RSP_READY=1 -> MEM_EN=1, MEM_WR=1, MEM_ADR=0 during the CLK-high phase; RSP_VALID 2 edges after accept; COUNT=1; RSP_ERR=0.
- Push 0x1..0x6 -> FULL=1, COUNT=6; a 7th push of 0xF -> RSP_ERR=1, COUNT stays 6, MEM_EN stays 0.
- From full: peek -> RSP_DATA=0x6, COUNT=6; pop six times -> RSP_DATA 0x6,0x5,...,0x1; then EMPTY=1.
- Pop when empty -> RSP_ERR=1, RSP_DATA=0, 1-edge latency. Clear with COUNT=4 -> COUNT=0 and EMPTY=1 with no memory strobe.
- Hold RSP_READY=0 for 5 cycles after a pop -> RSP_VALID and RSP_DATA stable and CMD_READY=0 throughout; the next command is accepted only after the handshake.
- Assert RST_N=0 during the WRITE cycle -> COUNT=0, no response, MEM_EN=0 by the next falling edge; a subsequent pop returns RSP_ERR=1.
